// File: rtl/alu_exec_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_exec_ctrl_if
// Instruction issue / retire bundle between an issuing agent (master) and the
// execute-stage controller alu_exec_ctrl (slave).
//   in_valid/in_ready       instruction handshake, transfer when both are 1
//   in_op                   ALUControl code of the instruction
//   in_rd/in_rs1/in_rs2     destination and source register addresses
//   done                    1-cycle retire pulse
//   err                     1-cycle reject pulse, only together with done
//   wb_data                 written value, meaningful while done=1
// ----------------------------------------------------------------------------
interface alu_exec_ctrl_if #(
    parameter int N  = 32,
    parameter int AW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic          done;
    logic          err;
    logic [N-1:0]  wb_data;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2,
        input  in_ready, done, err, wb_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2,
        output in_ready, done, err, wb_data
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// ----------------------------------------------------------------------------
// alu_exec_ctrl
// Execute-stage controller placed directly upstream of a combinational ALU.
// Holds a DEPTH-entry register file (r0 hard-wired to zero), accepts one
// instruction at a time, presents latched operands to the ALU, captures the
// ALU result/overflow and writes it back to rd. IDLE -> EXEC -> WB -> IDLE,
// so one instruction retires every three cycles.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   ins (slave)         instruction handshake and retire status
//   ld_en/addr/data     direct register-load strobe, usable in any state
//   alu_a/alu_b         operands to the ALU (hold value outside EXEC)
//   alu_ctrl            ALUControl to the ALU (holds value outside EXEC)
//   alu_result/overflow ALU outputs, sampled at the end of EXEC
//   ovf_sticky          set by any retired ADD/SUB overflow, cleared by reset
//   dbg_addr/dbg_data   combinational register-file read port
//
// Optional feature: define ALU_EXEC_OVF_TRAP_EN to reject an overflowing
// ADD/SUB in WB (no write, err=1, wb_data=0). Without it the wrapped result
// is written back normally.
// ----------------------------------------------------------------------------
module alu_exec_ctrl #(
    parameter int N     = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    alu_exec_ctrl_if.slave ins,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [N-1:0]  ld_data,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [2:0]    alu_ctrl,
    input  logic [N-1:0]  alu_result,
    input  logic          alu_overflow,
    output logic          ovf_sticky,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

`ifdef ALU_EXEC_OVF_TRAP_EN
    localparam bit OVF_TRAP = 1'b1;
`else
    localparam bit OVF_TRAP = 1'b0;
`endif

    function automatic logic op_legal(input logic [2:0] op);
        return op inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001);
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  res_q, res_d;
    logic          ovf_q, ovf_d;
    logic          ovf_sticky_q, ovf_sticky_d;
    logic [N-1:0]  rf_q [DEPTH];
    logic [N-1:0]  rf_d [DEPTH];
    logic          reject;

    // Operand/control registers only change on the accept edge, so the ALU
    // inputs stay stable from EXEC onward until the next instruction.
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = op_q;
    assign ovf_sticky = ovf_sticky_q;
    assign dbg_data   = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

    always_comb begin
        reject = !op_legal(op_q) || (OVF_TRAP && op_is_arith(op_q) && ovf_q);
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rd_d         = rd_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        ovf_d        = ovf_q;
        ovf_sticky_d = ovf_sticky_q;
        rf_d         = rf_q;
        ins.in_ready = 1'b0;
        ins.done     = 1'b0;
        ins.err      = 1'b0;
        ins.wb_data  = '0;

        // Load is applied first so a same-cycle writeback to the same
        // register overrides it.
        if (ld_en && (ld_addr != '0)) begin
            rf_d[ld_addr] = ld_data;
        end

        unique case (state_q)
            IDLE: begin
                ins.in_ready = 1'b1;
                if (ins.in_valid) begin
                    // Operands come from the pre-edge register file; a load in
                    // the same cycle is not forwarded.
                    op_d    = ins.in_op;
                    rd_d    = ins.in_rd;
                    a_d     = (ins.in_rs1 == '0) ? '0 : rf_q[ins.in_rs1];
                    b_d     = (ins.in_rs2 == '0) ? '0 : rf_q[ins.in_rs2];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                ovf_d   = alu_overflow;
                state_d = WB;
            end
            WB: begin
                ins.done = 1'b1;
                ins.err  = reject;
                if (!reject) begin
                    ins.wb_data = res_q;
                    if (rd_q != '0) begin
                        rf_d[rd_q] = res_q;
                    end
                end
                // Sticky flag records overflow even when the trap rejects it.
                if (op_is_arith(op_q) && ovf_q) begin
                    ovf_sticky_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 3'b000;
            rd_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            ovf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            ovf_q        <= ovf_d;
            ovf_sticky_q <= ovf_sticky_d;
            rf_q         <= rf_d;
        end
    end

endmodule
